// File: rtl/mskaes_128bits_ks_sequencer_pkg.sv
// Shared constants, types and helpers for the masked AES-128 key-schedule sequencer.
// The optional MSKAES_KS_ZEROIZE_EN build clears the key register after the final round key.
package mskaes_128bits_ks_sequencer_pkg;

    localparam int unsigned NROUNDS_DEF = 10;
    localparam int unsigned ROUND_W     = 4;
    localparam logic [7:0]  RCON_INIT   = 8'h01;
    localparam logic [7:0]  XTIME_POLY  = 8'h1B;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Cycle counter must hold 0..latency inclusive.
    function automatic int unsigned cnt_width(input int unsigned latency);
        return (latency < 1) ? 1 : $clog2(latency + 1);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mskaes_rcon_gen.sv
// RCON byte generator: advances by xtime on each capture and emits a shared byte
// (share 0 carries the value, other shares zero) only during the last cycle of a round.
module mskaes_rcon_gen
    import mskaes_128bits_ks_sequencer_pkg::*;
#(
    parameter int unsigned d = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           advance,
    input  logic           gate,
    output logic [8*d-1:0] sh_rcon
);

    logic [7:0] rcon_q;

    function automatic logic [8*d-1:0] share_byte(input logic [7:0] b);
        logic [8*d-1:0] s;
        s = '0;
        for (int k = 0; k < 8; k++) begin
            s[k*d] = b[k];
        end
        return s;
    endfunction

    // gate is asserted one cycle early so the registered byte lands on c==LATENCY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcon_q  <= RCON_INIT;
            sh_rcon <= '0;
        end else begin
            if (load) begin
                rcon_q <= RCON_INIT;
            end else if (advance) begin
                rcon_q <= xtime(rcon_q);
            end
            sh_rcon <= gate ? share_byte(rcon_q) : '0;
        end
    end

endmodule

// File: rtl/mskaes_128bits_ks_sequencer.sv
// Key-schedule sequencer around the masked AES-128 KS round: key register, round/cycle
// counters, RCON drive and round-key strobes. MSKAES_KS_ZEROIZE_EN clears the key after done.
module mskaes_128bits_ks_sequencer
    import mskaes_128bits_ks_sequencer_pkg::*;
#(
    parameter int unsigned d       = 2,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned NROUNDS = NROUNDS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [128*d-1:0]   sh_key_init,
    output logic [128*d-1:0]   sh_key_to_ks,
    input  logic [128*d-1:0]   sh_key_from_ks,
    output logic [8*d-1:0]     sh_RCON_out,
    output logic [128*d-1:0]   sh_round_key,
    output logic               round_key_valid,
    output logic [ROUND_W-1:0] round_idx,
    output logic               busy,
    output logic               done
);

    localparam int unsigned          CNT_W    = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0]     CNT_PRE  = CNT_W'(LATENCY - 1);
    localparam logic [ROUND_W-1:0]   RND_LAST = ROUND_W'(NROUNDS);

    state_t               state_q;
    logic [128*d-1:0]     key_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [ROUND_W-1:0]   rnd_q;
    logic [ROUND_W-1:0]   rnd_nxt_c;
    logic                 load_c;
    logic                 capture_c;
    logic                 rcon_gate_c;

    assign rnd_nxt_c    = rnd_q + ROUND_W'(1);
    assign load_c       = (state_q == IDLE) && start;
    assign capture_c    = (state_q == RUN) && (cnt_q == CNT_LAST);
    assign rcon_gate_c  = (state_q == RUN) && (cnt_q == CNT_PRE);
    assign sh_key_to_ks = key_q;
    assign sh_round_key = key_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            key_q           <= '0;
            cnt_q           <= '0;
            rnd_q           <= '0;
            round_key_valid <= 1'b0;
            round_idx       <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            round_key_valid <= 1'b0;
            done            <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        key_q           <= sh_key_init;
                        rnd_q           <= '0;
                        cnt_q           <= '0;
                        state_q         <= RUN;
                        round_key_valid <= 1'b1;
                        round_idx       <= '0;
                        busy            <= 1'b1;
                    end
`ifdef MSKAES_KS_ZEROIZE_EN
                    else if (done) begin
                        key_q <= '0;
                    end
`endif
                end
                RUN: begin
                    if (cnt_q == CNT_LAST) begin
                        key_q           <= sh_key_from_ks;
                        rnd_q           <= rnd_nxt_c;
                        cnt_q           <= '0;
                        round_key_valid <= 1'b1;
                        round_idx       <= rnd_nxt_c;
                        if (rnd_nxt_c == RND_LAST) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mskaes_rcon_gen #(
        .d(d)
    ) u_rcon_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_c),
        .advance (capture_c),
        .gate    (rcon_gate_c),
        .sh_rcon (sh_RCON_out)
    );

endmodule

// File: tb/tb_mskaes_128bits_ks_sequencer.sv
// Directed bench: a behavioural masked KS round closes the loop; FIPS-197 round keys checked.
module tb_mskaes_128bits_ks_sequencer;

    localparam int unsigned D       = 2;
    localparam int unsigned LATENCY = 4;
    localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start, start6;
    logic [255:0]   sh_key_init;
    logic [255:0]   sh_key_to_ks, sh_key_from_ks, sh_round_key;
    logic [15:0]    sh_rcon;
    logic           round_key_valid, busy, done;
    logic [3:0]     round_idx;
    logic [255:0]   sh_key_to_ks6, sh_key_from_ks6, sh_round_key6;
    logic [15:0]    sh_rcon6;
    logic           round_key_valid6, busy6, done6;
    logic [3:0]     round_idx6;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nstrobe, ndone, nrcon, done_idx, last_strobe;
    logic [127:0] key_at [16];
    int           t_at   [16];
    logic [255:0] prev_key = '0;
    int n6 = 0, t6_0 = 0, t6_10 = 0;
    logic [127:0] key6_10 = '0;
    logic [7:0] exp_rcon [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] unshare(input logic [255:0] s);
        logic [127:0] r;
        for (int k = 0; k < 128; k++) r[k] = s[2*k] ^ s[2*k+1];
        return r;
    endfunction

    function automatic logic [255:0] share(input logic [127:0] v, input logic [127:0] m);
        logic [255:0] s;
        for (int k = 0; k < 128; k++) begin
            s[2*k]   = v[k] ^ m[k];
            s[2*k+1] = m[k];
        end
        return s;
    endfunction

    function automatic logic [7:0] rcon_share(input logic [15:0] s, input int sh);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = s[2*k+sh];
        return b;
    endfunction

    // Behavioural masked KS round: unmask, expand one round, remask with the input's share 1.
    function automatic logic [255:0] ks_model(input logic [255:0] sk, input logic [15:0] sr);
        logic [127:0] k, m, nk;
        logic [31:0]  w0, w1, w2, w3, t;
        logic [7:0]   rc;
        k  = unshare(sk);
        rc = rcon_share(sr, 0) ^ rcon_share(sr, 1);
        for (int i = 0; i < 128; i++) m[i] = sk[2*i+1];
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        nk = {w0, w1, w2, w3};
        return share(nk, m);
    endfunction

    assign sh_key_from_ks  = ks_model(sh_key_to_ks, sh_rcon);
    assign sh_key_from_ks6 = ks_model(sh_key_to_ks6, sh_rcon6);

    mskaes_128bits_ks_sequencer #(.d(D), .LATENCY(LATENCY), .NROUNDS(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sh_key_init(sh_key_init),
        .sh_key_to_ks(sh_key_to_ks), .sh_key_from_ks(sh_key_from_ks),
        .sh_RCON_out(sh_rcon), .sh_round_key(sh_round_key),
        .round_key_valid(round_key_valid), .round_idx(round_idx),
        .busy(busy), .done(done)
    );

    mskaes_128bits_ks_sequencer #(.d(D), .LATENCY(6), .NROUNDS(10)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .sh_key_init(sh_key_init),
        .sh_key_to_ks(sh_key_to_ks6), .sh_key_from_ks(sh_key_from_ks6),
        .sh_RCON_out(sh_rcon6), .sh_round_key(sh_round_key6),
        .round_key_valid(round_key_valid6), .round_idx(round_idx6),
        .busy(busy6), .done(done6)
    );

    // Strobe, stability and RCON monitor for the LATENCY=4 instance.
    always @(negedge clk) begin
        if (round_key_valid) begin
            nstrobe++;
            key_at[round_idx] = unshare(sh_round_key);
            t_at[round_idx]   = cyc;
            last_strobe       = cyc;
            if (done) begin
                ndone++;
                done_idx = int'(round_idx);
            end
        end else if (busy) begin
            check("key_stable", sh_round_key, prev_key);
        end
        prev_key = sh_round_key;
        if (sh_rcon != 16'h0) begin
            check("rcon_pos", 128'(cyc - last_strobe), 128'(LATENCY));
            check("rcon_val", 128'(rcon_share(sh_rcon, 0)),
                  128'((nrcon < 10) ? exp_rcon[nrcon] : 8'h00));
            check("rcon_sh1", 128'(rcon_share(sh_rcon, 1)), 128'h0);
            nrcon++;
        end
    end

    always @(negedge clk) begin
        if (round_key_valid6) begin
            n6++;
            if (round_idx6 == 4'd0) t6_0 = cyc;
            if (round_idx6 == 4'd10) begin
                t6_10   = cyc;
                key6_10 = unshare(sh_round_key6);
            end
        end
    end

    task automatic clear_mon();
        nstrobe = 0; ndone = 0; nrcon = 0; done_idx = 0; last_strobe = cyc;
        for (int i = 0; i < 16; i++) begin
            key_at[i] = '0;
            t_at[i]   = 0;
        end
    endtask

    task automatic pulse_start(input bit with6);
        start = 1'b1;
        start6 = with6;
        @(posedge clk); #1;
        start = 1'b0;
        start6 = 1'b0;
        check("idx0_valid", 128'(round_key_valid), 128'd1);
        check("idx0_idx", 128'(round_idx), 128'd0);
        check("idx0_busy", 128'(busy), 128'd1);
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (!done && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", 128'(done), 128'd1);
        check("done_idx", 128'(round_idx), 128'd10);
        check("done_valid", 128'(round_key_valid), 128'd1);
        check("done_busy", 128'(busy), 128'd0);
    endtask

    task automatic check_run(input string tag);
        check({tag, "_strobes"}, 128'(nstrobe), 128'd11);
        check({tag, "_ndone"}, 128'(ndone), 128'd1);
        check({tag, "_done_idx"}, 128'(done_idx), 128'd10);
        check({tag, "_k0"}, key_at[0], K0);
        check({tag, "_k1"}, key_at[1], K1);
        check({tag, "_k2"}, key_at[2], K2);
        check({tag, "_k10"}, key_at[10], K10);
        check({tag, "_span"}, 128'(t_at[10] - t_at[0]), 128'd50);
        check({tag, "_nrcon"}, 128'(nrcon), 128'd10);
    endtask

    task automatic check_after_done();
        logic [127:0] exp_after;
`ifdef MSKAES_KS_ZEROIZE_EN
        exp_after = '0;
`else
        exp_after = K10;
`endif
        check("after_done_valid", 128'(round_key_valid), 128'd0);
        check("after_done_key", unshare(sh_round_key), exp_after);
    endtask

    initial begin
        int n;
        start = 1'b0;
        start6 = 1'b0;
        sh_key_init = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", 128'(round_key_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_idx", 128'(round_idx), 128'd0);
        check("rst_key", sh_round_key[127:0], 128'h0);
        check("rst_rcon", 128'(sh_rcon), 128'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Run 1: plain run, alongside the LATENCY=6 instance.
        clear_mon();
        sh_key_init = share(K0, {$urandom(), $urandom(), $urandom(), $urandom()});
        pulse_start(1'b1);
        check("idx0_key", unshare(sh_round_key), K0);
        wait_done(100);
        @(posedge clk); #1;
        check_run("run1");
        check_after_done();
        n = 0;
        while (n6 < 11 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("lat6_strobes", 128'(n6), 128'd11);
        check("lat6_span", 128'(t6_10 - t6_0), 128'd70);
        check("lat6_k10", key6_10, K10);

        // Run 2: start held high; second run starts in the done cycle.
        clear_mon();
        sh_key_init = share(K0, {$urandom(), $urandom(), $urandom(), $urandom()});
        pulse_start(1'b0);
        start = 1'b1;
        wait_done(100);
        @(posedge clk); #1;
        check("restart_valid", 128'(round_key_valid), 128'd1);
        check("restart_idx", 128'(round_idx), 128'd0);
        check("restart_busy", 128'(busy), 128'd1);
        check_run("run2a");
        clear_mon();
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        wait_done(100);
        @(posedge clk); #1;
        check("run2b_strobes", 128'(nstrobe), 128'd11);
        check("run2b_k10", key_at[10], K10);

        // Run 3: asynchronous reset at round 5, c==2, then a clean rerun.
        clear_mon();
        sh_key_init = share(K0, {$urandom(), $urandom(), $urandom(), $urandom()});
        pulse_start(1'b0);
        n = 0;
        while (!(round_key_valid && round_idx == 4'd4) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_idx4", 128'(round_idx), 128'd4);
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 128'(round_key_valid), 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_done", 128'(done), 128'd0);
        check("abort_idx", 128'(round_idx), 128'd0);
        check("abort_key_lo", sh_round_key[127:0], 128'h0);
        check("abort_key_hi", sh_round_key[255:128], 128'h0);
        check("abort_to_ks", sh_key_to_ks[127:0], 128'h0);
        check("abort_rcon", 128'(sh_rcon), 128'h0);
        check("abort_ndone", 128'(ndone), 128'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        clear_mon();
        pulse_start(1'b0);
        wait_done(100);
        @(posedge clk); #1;
        check_run("run3");
        check_after_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mskaes_128bits_ks_sequencer.md
Name: mskaes_128bits_ks_sequencer

Overview:
- Control and state stage wrapped around the 128-bit masked key-schedule round (KS round).
- Holds the shared key register and drives the KS round input from it.
- Counts the cycles of each round and drives the shared RCON byte in the KS round's last cycle.
- Captures the KS round output and presents the 11 masked round keys, with strobes, to the masked AES datapath.

Parameters:
- d, 2, number of shares.
- LATENCY, 4, pipeline latency of the KS round; must equal the KS round instance parameter.
- NROUNDS, 10, number of key-expansion rounds for AES-128.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin expansion; sampled only while busy=0.
- sh_key_init  in  128*d  shared cipher key; sampled on an accepted start.
- sh_key_to_ks  out  128*d  key register contents, to KS sh_key_in.
- sh_key_from_ks  in  128*d  KS sh_key_out.
- sh_RCON_out  out  8*d  shared RCON byte, to KS sh_RCON_in.
- sh_round_key  out  128*d  current round key (same as key register).
- round_key_valid  out  1  one-cycle strobe: sh_round_key holds a new round key.
- round_idx  out  4  index 0..NROUNDS of sh_round_key.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse with the final round_key_valid.

Behaviour:
- Sharing layout: byte bit k occupies [k*d +: d]; share 0 is at bit k*d.
- RCON is injected as share 0 = rcon bit; all other shares = 0.
- Reset (asynchronous, rst_n=0):
  - state=IDLE; key register=0; cycle counter=0; round counter=0.
  - All outputs 0.
- FSM states IDLE and RUN.
- IDLE, start=1 at edge E:
  - key register <= sh_key_init; round counter=0; cycle counter c=0; state=RUN.
  - Cycle after E: round_key_valid=1, round_idx=0, busy=1.
- RUN, cycle counter c counts 0..LATENCY; one round is LATENCY+1 cycles:
  - sh_key_to_ks is held stable for the whole round.
  - c==LATENCY: sh_RCON_out = shared rcon[r] for round r (1-based); otherwise sh_RCON_out=0.
  - Edge ending c==LATENCY: key register <= sh_key_from_ks; round counter increments; c wraps to 0.
  - Next cycle: round_key_valid=1, round_idx=r.
- RCON sequence: 01,02,04,08,10,20,40,80,1B,36, produced by xtime (shift left; XOR 0x1B on carry) from 0x01.
- After the NROUNDS capture:
  - Next cycle: round_key_valid=1, round_idx=NROUNDS, done=1.
  - In that same cycle busy=0 and state=IDLE.
- Timing: round_idx 0 strobe to round_idx NROUNDS strobe = NROUNDS*(LATENCY+1) cycles; 50 at the defaults.
- Boundary conditions:
  - start while busy=1 is ignored; no restart.
  - start in the done cycle is accepted; the new key loads at that edge.
  - rst_n low mid-run aborts immediately: no done, all outputs 0.
  - round_key_valid is 0 in every cycle other than the strobe cycles above.
  - sh_round_key is stable between strobes.

Optional Feature:
- Macro: MSKAES_KS_ZEROIZE_EN.
- Defined: at the edge ending the done cycle, the key register is cleared to 0, unless a start is accepted at that edge.
- Not defined: the key register retains round key NROUNDS until the next start or reset.

Decomposition:
- Shared package holds:
  - NROUNDS default.
  - RCON initial value (0x01) and xtime polynomial (0x1B).
  - State enum (IDLE/RUN).
  - Widths of the cycle counter (clog2(LATENCY+1)) and round counter (4 bits).
- One sub-module: mskaes_rcon_gen. It contains:
  - the rcon register (reset and load to 0x01, advance by xtime on each capture);
  - share expansion to 8*d bits;
  - gating to zero outside c==LATENCY.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, shares 1..d-1 random, with the KS round instantiated; check recombined round keys:
  - idx1 = a0fafe1788542cb123a339392a6c7605;
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - exactly 11 strobes; done with idx10.
- Monitor sh_RCON_out over a run: nonzero only at c==LATENCY; share 0 values 01..36 in order; other shares always 0.
- start held high throughout a run: the run is unaffected; a second run starts in the done cycle and its idx0 strobe immediately follows the done cycle.
- rst_n pulsed low at round 5, c==2: all outputs 0 asynchronously; the next start gives a full 11-strobe run with the correct keys.
- LATENCY=6: idx0 to idx10 spacing is 70 cycles; keys are identical to the LATENCY=4 run.
- MSKAES_KS_ZEROIZE_EN defined: sh_round_key=0 the cycle after done. Not defined: it holds the idx10 key (d014f9a8…).
